max_stream_reduce: RTL
======================

Name: max_stream_reduce

Overview:
- Sequential argmax stage directly upstream of the combinational signed max comparator.
- Accepts a valid/ready stream of signed Data_Width elements and tags each with its position in the window (0..len-1).
- Folds the stream through one max_signed instance and emits a single packed {index, data} winner per window.
- Used for max-pooling and argmax over feature-map rows; the output format matches the comparator's packed operand format, so reducers can cascade.

Parameters:
- Data_Width, 8, signed element width.
- Index_Width, 16, position-tag width and window-length width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- cfg_len  in  Index_Width  window length; latched on accepted start.
- in_valid  in  1  input element valid.
- in_ready  out  1  input element accepted when in_valid && in_ready.
- in_data  in  Data_Width  signed input element.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  Index_Width+Data_Width  {index, data}; data in the low Data_Width bits, index in the upper Index_Width bits.
- busy  out  1  high in ACCUM and OUT.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, state=IDLE; counter, best register and latched length all 0.
- Reset asserted mid-window discards the partial result; no output is produced for that window.
- IDLE:
  - start && cfg_len!=0: latch len, clear counter, go to ACCUM.
  - start && cfg_len==0: ignored; stay in IDLE.
- ACCUM:
  - in_ready=1 combinationally in this state only.
  - Each accepted element is tagged cand = {cnt, in_data}.
  - cnt==0: best <= cand, with no comparison.
  - cnt>0: best <= max_signed(ain=best, bin=cand).
  - Ties keep ain, so the earliest index wins among equal values.
  - Comparison is signed two's-complement on the low Data_Width bits only; the index never affects the compare.
  - cnt increments on each acceptance.
  - When the accepted element has cnt==len-1, the next state is OUT.
- OUT:
  - out_valid=1 and out_data=best, held stable until out_ready.
  - On out_valid && out_ready: go to IDLE, out_valid drops next cycle.
  - A start in that same cycle is ignored; start is sampled only in IDLE.
- Latency: out_valid rises the cycle after the last element is accepted. With in_valid held high, a window of N elements takes start + N + 1 cycles to out_valid.
- Throughput: one element per cycle in ACCUM; the block is never back-pressured internally.
- Boundaries:
  - len=1: out_data={0, first element}.
  - len=2^Index_Width-1: maximum index is len-1; the counter does not wrap within a window.
  - in_valid low stalls ACCUM indefinitely with no state change.
  - out_ready held low keeps OUT and out_data stable.
  - Inputs of 0x80 (most negative) and 0x7F (most positive) must compare correctly.

Decomposition:
- Shared package holds:
  - default Data_Width and Index_Width;
  - FSM state encoding: IDLE=2'd0, ACCUM=2'd1, OUT=2'd2;
  - the packed {index, data} field offsets, used by the comparator and its neighbours.
- One sub-module instance: max_signed (existing comparator) with Data_Width and Index_Width passed through.
- No other sub-modules.

Test Plan:
- len=4, in_data=3,-5,7,2 streamed back-to-back -> out_data={16'd2, 8'h07}, out_valid on cycle 6 after start.
- len=3, in_data=-1,-1,-2 -> out_data={16'd0, 8'hFF} (tie keeps earliest index).
- len=2, in_data=0x80 then 0x7F -> out_data={16'd1, 8'h7F}; then len=2, in_data=0x7F then 0x80 -> {16'd0, 8'h7F}.
- len=1, in_data=-128 -> {16'd0, 8'h80}; a start with cfg_len=0 -> busy stays 0 and no out_valid ever rises.
- Random in_valid gaps plus out_ready held low for 5 cycles -> result unchanged; in_ready=0 throughout OUT; a start during OUT is ignored.
- rst pulsed after 2 of 4 elements -> all outputs 0 and IDLE; the next window len=2, in_data=5,6 -> {16'd1, 8'h06} with no stale data.

Source files
------------

// File: rtl/max_stream_reduce_pkg.sv
// Shared definitions for the streaming signed argmax reducer and its comparator.
package max_stream_reduce_pkg;

  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned INDEX_WIDTH = 16;

  // Packed operand layout: {index, data}, data in the low bits.
  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned INDEX_LSB = DATA_LSB + DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

endpackage

// File: rtl/max_signed.sv
// Combinational signed max over packed {index, data} operands; ties keep ain.
module max_signed
  import max_stream_reduce_pkg::*;
#(
  parameter int unsigned Data_Width  = DATA_WIDTH,
  parameter int unsigned Index_Width = INDEX_WIDTH
) (
  input  logic [Index_Width+Data_Width-1:0] ain,
  input  logic [Index_Width+Data_Width-1:0] bin,
  output logic [Index_Width+Data_Width-1:0] max_c
);

  logic signed [Data_Width-1:0] a_val;
  logic signed [Data_Width-1:0] b_val;

  assign a_val = ain[DATA_LSB +: Data_Width];
  assign b_val = bin[DATA_LSB +: Data_Width];

  // Strictly-greater selects bin so the earlier (ain) operand wins ties.
  always_comb begin
    max_c = ain;
    if (b_val > a_val) begin
      max_c = bin;
    end
  end

endmodule

// File: rtl/max_stream_reduce.sv
// Sequential argmax: folds a window of signed elements into one {index, data} winner.
module max_stream_reduce
  import max_stream_reduce_pkg::*;
#(
  parameter int unsigned Data_Width  = DATA_WIDTH,
  parameter int unsigned Index_Width = INDEX_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [Index_Width-1:0]            cfg_len,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [Data_Width-1:0]             in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [Index_Width+Data_Width-1:0] out_data,
  output logic                              busy
);

  localparam int unsigned PackW = Index_Width + Data_Width;

  state_t                 state;
  logic [Index_Width-1:0] len;
  logic [Index_Width-1:0] cnt;
  logic [PackW-1:0]       best;
  logic [PackW-1:0]       cand;
  logic [PackW-1:0]       best_next_c;
  logic                   accept;

  assign cand   = {cnt, in_data};
  assign accept = in_valid && in_ready;

  max_signed #(
    .Data_Width (Data_Width),
    .Index_Width(Index_Width)
  ) u_max_signed (
    .ain  (best),
    .bin  (cand),
    .max_c(best_next_c)
  );

  // The best register is the result; it only changes on accepted elements.
  assign out_data = best;

  // Window FSM; in_ready/out_valid/busy are registered alongside the state they mirror.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      cnt       <= '0;
      best      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (cfg_len != '0)) begin
            len      <= cfg_len;
            cnt      <= '0;
            state    <= ACCUM;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept) begin
            best <= (cnt == '0) ? cand : best_next_c;
            cnt  <= cnt + Index_Width'(1);
            if (cnt == len - Index_Width'(1)) begin
              state     <= OUT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
